updown_cnt_bounded: RTL and testbench
=====================================

// Module: updown_cnt_bounded
// PURPOSE
//  Parametrised up/down counter, next generation of the plain N-bit up/down counter.
//  - Adds programmable step, runtime lower/upper limits, wrap or saturate mode,
//    parallel load, terminal flags and overflow/underflow event pulses.
//  - Used as a general event/credit/position counter in datapath and control blocks.
// PARAMETERS
//  N        32  counter width (Vout, Load_val, Lim_lo, Lim_hi)
//  S        4   step width; step range 0..2^S-1
//  RST_VAL  0   value of Vout after Rst/Pwr_off (N bits)
// PORTS
//  Clk       in   1  clock, all state on rising edge
//  Rst       in   1  synchronous reset, active-high
//  Pwr_off   in   1  synchronous power-off clear, active-high, same effect as Rst
//  En        in   1  count enable; gates Up/Down only (Load not gated)
//  Up        in   1  count up by Step
//  Down      in   1  count down by Step
//  Step      in   S  increment/decrement magnitude
//  Sat_mode  in   1  0 = wrap at limits, 1 = saturate at limits
//  Lim_lo    in   N  lower limit, inclusive
//  Lim_hi    in   N  upper limit, inclusive
//  Load      in   1  parallel load strobe
//  Load_val  in   N  value for Load
//  Vout      out  N  counter value (registered)
//  At_max    out  1  Vout == Lim_hi (combinational on Vout and Lim_hi)
//  At_min    out  1  Vout == Lim_lo (combinational on Vout and Lim_lo)
//  Ovf       out  1  one-cycle pulse: up-count crossed Lim_hi (registered)
//  Unf       out  1  one-cycle pulse: down-count crossed Lim_lo (registered)
//  Cfg_err   out  1  Lim_lo > Lim_hi (combinational)
// BEHAVIOUR
//  Reset: Rst|Pwr_off -> Vout=RST_VAL; Ovf=0; Unf=0; sticky bits=0. Overrides all inputs.
//  Priority, highest first:
//   Rst/Pwr_off > Cfg_err (hold) > Load > !En (hold) > Up&Down (hold) > Up > Down > hold.
//  Latency: 1 cycle. Vout updates on the edge that samples the command.
//  Arithmetic: unsigned, evaluated at N+1 bits. Step is zero-extended.
//  Up: t = Vout + Step.
//   - t <= Lim_hi -> Vout = t.
//   - Otherwise Ovf=1 next cycle; Vout = Lim_hi if Sat_mode, else Lim_lo.
//  Down: t = Vout - Step, borrow-aware.
//   - t >= Lim_lo and no borrow -> Vout = t.
//   - Otherwise Unf=1; Vout = Lim_lo if Sat_mode, else Lim_hi.
//  Wrap lands exactly on the opposite limit. There is no modular remainder carry-over.
//  Step=0: Vout holds, no Ovf/Unf, even at a limit.
//  Load: Vout = Load_val clamped to [Lim_lo, Lim_hi]. No Ovf/Unf on load.
//  Vout outside the limits (limits changed at runtime):
//   - Next Up/Down applies the rules above, so the out-of-range condition flags.
//   - Holds otherwise.
//  Cfg_err=1: Vout frozen, Ovf=Unf=0. Load is also ignored. Rst still applies.
//  Ovf/Unf are pulses: 1 for exactly the cycle after the offending edge, 0 otherwise.
// CONFIGURATION
//  UPDOWN_CNT_STICKY_EN defined:
//   - Adds input Sticky_clr (1) and outputs Ovf_sticky (1), Unf_sticky (1).
//   - A sticky bit sets with its pulse and holds until Sticky_clr or reset.
//   - Set wins over a same-cycle Sticky_clr.
//  UPDOWN_CNT_STICKY_EN undefined: these ports and registers are absent. Core behaviour is identical.
// STRUCTURE
//  updown_cnt_pkg:
//   - command encoding localparams (CMD_HOLD/LOAD/UP/DOWN)
//   - mode constants (MODE_WRAP=0, MODE_SAT=1)
//  Sub-module updown_cnt_next (combinational):
//   - Inputs: Vout, Step, limits, mode, cmd.
//   - Outputs: next value, ovf, unf.
//   - Top holds only the registers, priority decode and flags.
// TESTING
//  1 Reset/off: N=8, RST_VAL=5, drive Up; pulse Rst, then Pwr_off -> Vout=5 the next cycle, Ovf=Unf=0.
//  2 Wrap: Lim=[10,20], Vout=18, Step=3, Up -> Vout=10, Ovf pulse 1 cycle.
//    Down from 11, Step=2 -> Vout=20, Unf=1.
//  3 Saturate: Sat_mode=1, Lim=[0,255], N=8, Vout=254, Step=5, Up -> Vout=255, Ovf=1.
//    Repeat -> 255 and Ovf=1 again.
//    Down from 0 -> 0, Unf=1, no borrow wrap.
//  4 Priority: Load=1 with Up=Down=1, Load_val=300, Lim=[0,200] -> Vout=200.
//    Up=Down=1, En=1 -> hold. En=0, Up -> hold.
//  5 Cfg_err: Lim_lo=50, Lim_hi=40 -> Cfg_err=1; Up/Load ignored.
//    Restore limits -> counting resumes from the frozen value.
//  6 Sticky (macro on):
//    - Ovf event -> Ovf_sticky=1 and stays 1 for 10 idle cycles.
//    - Sticky_clr -> 0.
//    - Clear coincident with a new Ovf -> stays 1.

Source files
------------

// File: rtl/updown_cnt_pkg.sv
// ============================================================================
// updown_cnt_pkg : command and mode encodings shared by the bounded counter
// Revision 1.0
// ============================================================================
`default_nettype none

package updown_cnt_pkg;

   typedef logic [1:0] cmd_t;

   localparam cmd_t CMD_HOLD = 2'd0;
   localparam cmd_t CMD_LOAD = 2'd1;
   localparam cmd_t CMD_UP   = 2'd2;
   localparam cmd_t CMD_DOWN = 2'd3;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage : updown_cnt_pkg

`default_nettype wire

// File: rtl/updown_cnt_next.sv
// ============================================================================
// updown_cnt_next : combinational next-value, overflow and underflow logic
// Revision 1.0
// ============================================================================
`default_nettype none

module updown_cnt_next
   import updown_cnt_pkg::*;
#(
   parameter int N = 32,
   parameter int S = 4
) (
   input  logic [N-1:0] i_vout,
   input  logic [S-1:0] i_step,
   input  logic [N-1:0] i_lim_lo,
   input  logic [N-1:0] i_lim_hi,
   input  logic [N-1:0] i_load_val,
   input  logic         i_mode,
   input  cmd_t         i_cmd,
   output logic [N-1:0] o_next,
   output logic         o_ovf,
   output logic         o_unf
);

   logic [N:0] w_step_x;
   logic [N:0] w_sum;
   logic [N:0] w_diff;

   // One extra bit keeps the carry of an up-count and the borrow of a down-count
   assign w_step_x = (N+1)'(i_step);
   assign w_sum    = {1'b0, i_vout} + w_step_x;
   assign w_diff   = {1'b0, i_vout} - w_step_x;

   always_comb begin
      o_next = i_vout;
      o_ovf  = 1'b0;
      o_unf  = 1'b0;
      case (i_cmd)
         CMD_LOAD: begin
            if (i_load_val < i_lim_lo)
               o_next = i_lim_lo;
            else if (i_load_val > i_lim_hi)
               o_next = i_lim_hi;
            else
               o_next = i_load_val;
         end
         CMD_UP: begin
            if (i_step != '0) begin
               if (w_sum <= {1'b0, i_lim_hi}) begin
                  o_next = w_sum[N-1:0];
               end else begin
                  o_ovf  = 1'b1;
                  o_next = (i_mode == MODE_SAT) ? i_lim_hi : i_lim_lo;
               end
            end
         end
         CMD_DOWN: begin
            if (i_step != '0) begin
               if (!w_diff[N] && (w_diff[N-1:0] >= i_lim_lo)) begin
                  o_next = w_diff[N-1:0];
               end else begin
                  o_unf  = 1'b1;
                  o_next = (i_mode == MODE_SAT) ? i_lim_lo : i_lim_hi;
               end
            end
         end
         default: ;
      endcase
   end

endmodule : updown_cnt_next

`default_nettype wire

// File: rtl/updown_cnt_bounded.sv
// ============================================================================
// updown_cnt_bounded : bounded up/down counter with step, wrap/saturate, load
// Optional sticky event bits: define UPDOWN_CNT_STICKY_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module updown_cnt_bounded
   import updown_cnt_pkg::*;
#(
   parameter int           N       = 32,
   parameter int           S       = 4,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_pwr_off,
   input  logic         i_en,
   input  logic         i_up,
   input  logic         i_down,
   input  logic [S-1:0] i_step,
   input  logic         i_sat_mode,
   input  logic [N-1:0] i_lim_lo,
   input  logic [N-1:0] i_lim_hi,
   input  logic         i_load,
   input  logic [N-1:0] i_load_val,
`ifdef UPDOWN_CNT_STICKY_EN
   input  logic         i_sticky_clr,
   output logic         o_ovf_sticky,
   output logic         o_unf_sticky,
`endif
   output logic [N-1:0] o_vout,
   output logic         o_at_max,
   output logic         o_at_min,
   output logic         o_ovf,
   output logic         o_unf,
   output logic         o_cfg_err
);

   logic [N-1:0] r_vout;
   logic         r_ovf;
   logic         r_unf;
   logic         w_clear;
   logic         w_cfg_err;
   cmd_t         w_cmd;
   logic [N-1:0] w_next;
   logic         w_ovf;
   logic         w_unf;

   assign w_clear   = i_rst | i_pwr_off;
   assign w_cfg_err = (i_lim_lo > i_lim_hi);

   // Inverted limits freeze the counter; Load is gated by that but not by En
   always_comb begin
      w_cmd = CMD_HOLD;
      if (w_cfg_err)
         w_cmd = CMD_HOLD;
      else if (i_load)
         w_cmd = CMD_LOAD;
      else if (!i_en || (i_up && i_down))
         w_cmd = CMD_HOLD;
      else if (i_up)
         w_cmd = CMD_UP;
      else if (i_down)
         w_cmd = CMD_DOWN;
   end

   updown_cnt_next #(
      .N (N),
      .S (S)
   ) u_next (
      .i_vout     (r_vout),
      .i_step     (i_step),
      .i_lim_lo   (i_lim_lo),
      .i_lim_hi   (i_lim_hi),
      .i_load_val (i_load_val),
      .i_mode     (i_sat_mode),
      .i_cmd      (w_cmd),
      .o_next     (w_next),
      .o_ovf      (w_ovf),
      .o_unf      (w_unf)
   );

   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         r_vout <= RST_VAL;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else begin
         r_vout <= w_next;
         r_ovf  <= w_ovf;
         r_unf  <= w_unf;
      end
   end

`ifdef UPDOWN_CNT_STICKY_EN
   logic r_ovf_sticky;
   logic r_unf_sticky;

   // A new event outranks a same-cycle clear
   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         r_ovf_sticky <= 1'b0;
         r_unf_sticky <= 1'b0;
      end else begin
         if (w_ovf)
            r_ovf_sticky <= 1'b1;
         else if (i_sticky_clr)
            r_ovf_sticky <= 1'b0;
         if (w_unf)
            r_unf_sticky <= 1'b1;
         else if (i_sticky_clr)
            r_unf_sticky <= 1'b0;
      end
   end

   assign o_ovf_sticky = r_ovf_sticky;
   assign o_unf_sticky = r_unf_sticky;
`endif

   assign o_vout    = r_vout;
   assign o_ovf     = r_ovf;
   assign o_unf     = r_unf;
   assign o_at_max  = (r_vout == i_lim_hi);
   assign o_at_min  = (r_vout == i_lim_lo);
   assign o_cfg_err = w_cfg_err;

endmodule : updown_cnt_bounded

`default_nettype wire

// File: tb/tb_updown_cnt_bounded.sv
// ============================================================================
// tb_updown_cnt_bounded : scoreboard bench for updown_cnt_bounded (N=8, RST_VAL=5)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_updown_cnt_bounded;

   localparam int N  = 8;
   localparam int S  = 4;
   localparam int RV = 5;

   logic         clk = 1'b0;
   logic         rst, pwr_off, en, up, down, sat, load, sticky_clr;
   logic [S-1:0] step;
   logic [N-1:0] lo, hi, lval;
   logic [N-1:0] vout;
   logic         at_max, at_min, ovf, unf, cfg_err;
   logic         ovf_st, unf_st;

   typedef struct {
      int v;
      bit o;
      bit u;
      bit os;
      bit us;
   } exp_t;

   exp_t  q[$];
   int    m_v  = 0;
   bit    m_os = 1'b0;
   bit    m_us = 1'b0;
   int    n_tests = 0;
   int    n_fail  = 0;
   string phase = "init";

   always #5 clk = ~clk;

   updown_cnt_bounded #(
      .N       (N),
      .S       (S),
      .RST_VAL (8'(RV))
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_pwr_off    (pwr_off),
      .i_en         (en),
      .i_up         (up),
      .i_down       (down),
      .i_step       (step),
      .i_sat_mode   (sat),
      .i_lim_lo     (lo),
      .i_lim_hi     (hi),
      .i_load       (load),
      .i_load_val   (lval),
`ifdef UPDOWN_CNT_STICKY_EN
      .i_sticky_clr (sticky_clr),
      .o_ovf_sticky (ovf_st),
      .o_unf_sticky (unf_st),
`endif
      .o_vout       (vout),
      .o_at_max     (at_max),
      .o_at_min     (at_min),
      .o_ovf        (ovf),
      .o_unf        (unf),
      .o_cfg_err    (cfg_err)
   );

`ifndef UPDOWN_CNT_STICKY_EN
   assign ovf_st = 1'b0;
   assign unf_st = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
      end
   endtask

   // Reference model evaluated on the inputs present before the edge
   task automatic push_expect();
      exp_t e;
      int   li, hi_i, lv, t;
      li   = int'(lo);
      hi_i = int'(hi);
      lv   = int'(lval);
      e.v  = m_v;
      e.o  = 1'b0;
      e.u  = 1'b0;
      if (rst || pwr_off) begin
         e.v = RV;
      end else if (li > hi_i) begin
         e.v = m_v;
      end else if (load) begin
         e.v = (lv < li) ? li : ((lv > hi_i) ? hi_i : lv);
      end else if (en && (up != down) && (step != 0)) begin
         if (up) begin
            t = m_v + int'(step);
            if (t <= hi_i) e.v = t;
            else begin e.o = 1'b1; e.v = sat ? hi_i : li; end
         end else begin
            t = m_v - int'(step);
            if (t >= li) e.v = t;
            else begin e.u = 1'b1; e.v = sat ? li : hi_i; end
         end
      end
      if (rst || pwr_off) begin
         e.os = 1'b0;
         e.us = 1'b0;
      end else begin
         e.os = e.o ? 1'b1 : (sticky_clr ? 1'b0 : m_os);
         e.us = e.u ? 1'b1 : (sticky_clr ? 1'b0 : m_us);
      end
      m_v  = e.v;
      m_os = e.os;
      m_us = e.us;
      q.push_back(e);
   endtask

   task automatic cyc();
      exp_t e;
      push_expect();
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("vout",    32'(vout),    32'(e.v));
      check("ovf",     32'(ovf),     32'(e.o));
      check("unf",     32'(unf),     32'(e.u));
      check("at_max",  32'(at_max),  32'(e.v == int'(hi)));
      check("at_min",  32'(at_min),  32'(e.v == int'(lo)));
      check("cfg_err", 32'(cfg_err), 32'(lo > hi));
`ifdef UPDOWN_CNT_STICKY_EN
      check("ovf_sticky", 32'(ovf_st), 32'(e.os));
      check("unf_sticky", 32'(unf_st), 32'(e.us));
`endif
   endtask

   task automatic idle();
      rst = 0; pwr_off = 0; en = 1; up = 0; down = 0; load = 0; sticky_clr = 0;
   endtask

   task automatic do_load(input int v);
      load = 1; lval = 8'(v); cyc(); load = 0;
   endtask

   initial begin
      idle();
      sat = 0; step = 1; lo = 0; hi = 255; lval = 0;

      phase = "reset";
      rst = 1; up = 1; cyc();
      rst = 0; cyc();
      rst = 1; cyc();
      rst = 0; cyc();
      pwr_off = 1; cyc();
      pwr_off = 0; up = 0; cyc();

      phase = "wrap";
      lo = 10; hi = 20;
      do_load(18);
      up = 1; step = 3; cyc();
      up = 0; cyc();
      do_load(11);
      down = 1; step = 2; cyc();
      down = 0; cyc();

      phase = "sat";
      sat = 1; lo = 0; hi = 255;
      do_load(254);
      up = 1; step = 5; cyc();
      cyc();
      up = 0;
      do_load(0);
      down = 1; cyc();
      down = 0; cyc();

      phase = "step0";
      do_load(255);
      up = 1; step = 0; cyc();
      up = 0;
      do_load(0);
      down = 1; cyc();
      down = 0;

      phase = "prio";
      sat = 0; lo = 0; hi = 200; step = 1;
      load = 1; up = 1; down = 1; lval = 250; cyc();
      load = 0; cyc();
      down = 0; en = 0; cyc();
      en = 1; up = 0;

      phase = "cfg";
      lo = 50; hi = 40;
      up = 1; cyc();
      up = 0;
      do_load(45);
      lo = 0; hi = 255;
      up = 1; cyc();
      up = 0;

      phase = "range";
      lo = 0; hi = 100; cyc();
      up = 1; cyc();
      up = 0;
      lo = 50; down = 1; cyc();
      down = 0; cyc();

`ifdef UPDOWN_CNT_STICKY_EN
      phase = "sticky";
      sat = 1; lo = 0; hi = 100;
      do_load(100);
      up = 1; cyc();
      up = 0;
      for (int i = 0; i < 10; i++) cyc();
      sticky_clr = 1; cyc();
      sticky_clr = 0; cyc();
      sticky_clr = 1; up = 1; cyc();
      sticky_clr = 0; up = 0; cyc();
      sat = 0;
`endif

      phase = "random";
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 49) == 0);
         pwr_off    = ($urandom_range(0, 79) == 0);
         en         = ($urandom_range(0, 7) != 0);
         up         = $urandom_range(0, 1);
         down       = $urandom_range(0, 1);
         load       = ($urandom_range(0, 9) == 0);
         sticky_clr = ($urandom_range(0, 7) == 0);
         sat        = $urandom_range(0, 1);
         step       = S'($urandom_range(0, 15));
         lval       = N'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0) begin
            lo = N'($urandom_range(0, 80));
            hi = N'($urandom_range(60, 255));
         end
         cyc();
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_updown_cnt_bounded

`default_nettype wire
